// File: rtl/dma_sample_fifo.sv
// dma_sample_fifo: decimates ADC/PDH sample pairs and packs two kept pairs into
// each 64-bit word. Words go into a first-word-fall-through FIFO that the HP0
// DMA write engine drains over valid/ready. Word count and sticky overflow let
// software check that a capture buffer has no gaps.
module dma_sample_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             aclk,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             capture_en_i,
  input  logic [15:0]      decim_i,
  input  logic [15:0]      sample_a_i,
  input  logic [15:0]      sample_b_i,
  input  logic             sample_valid_i,
  output logic [63:0]      m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [LVL_W-1:0] level_o,
  output logic             overflow_o,
  output logic [31:0]      words_written_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic             r_cap_d;
  logic [15:0]      r_decim;
  logic [15:0]      r_cnt;
  logic             r_half;
  logic [31:0]      r_lo;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ovf;
  logic [31:0]      r_words;
  logic [63:0]      r_mem [DEPTH];

  logic        w_rise;
  logic [15:0] w_cnt_eff;
  logic [15:0] w_decim_eff;
  logic        w_strobe;
  logic        w_keep;
  logic        w_complete;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic [63:0] w_word;

  // A strobe on the enable's rising edge already sees the fresh decim value and
  // a zero counter, so the first pair of every capture is always kept.
  assign w_rise      = capture_en_i & ~r_cap_d;
  assign w_cnt_eff   = w_rise ? '0 : r_cnt;
  assign w_decim_eff = w_rise ? decim_i : r_decim;
  assign w_strobe    = capture_en_i & sample_valid_i;
  assign w_keep      = w_strobe & (w_cnt_eff == '0);
  assign w_complete  = w_keep & r_half;
  assign w_word      = {sample_a_i, sample_b_i, r_lo};

  assign w_pop  = (r_level != '0) & m_ready_i & ~clear_i;
  assign w_push = w_complete & ~clear_i & ((r_level != FULL_LVL) | w_pop);
  assign w_drop = w_complete & ~clear_i & (r_level == FULL_LVL) & ~w_pop;

  // Enable edge detect, decim latch and keep-one-in-N counter
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      r_cap_d <= 1'b0;
      r_decim <= '0;
      r_cnt   <= '0;
    end else begin
      r_cap_d <= capture_en_i;
      if (w_rise) r_decim <= decim_i;
      if (clear_i)       r_cnt <= '0;
      else if (w_keep)   r_cnt <= w_decim_eff;
      else if (w_strobe) r_cnt <= w_cnt_eff - 16'd1;
      else               r_cnt <= w_cnt_eff;
    end
  end

  // Packer: hold the low-half pair until its partner arrives; drop it when capture stops
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      r_half <= 1'b0;
      r_lo   <= '0;
    end else if (clear_i || !capture_en_i) begin
      r_half <= 1'b0;
    end else if (w_keep) begin
      r_half <= ~r_half;
      if (!r_half) r_lo <= {sample_a_i, sample_b_i};
    end
  end

  // FIFO pointers, level, overflow flag and accepted-word counter
  always_ff @(posedge aclk or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_words  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_words  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_words  <= r_words + 32'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Word storage; contents are never read while empty, so it needs no reset
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  assign m_valid_o       = (r_level != '0);
  assign m_data_o        = m_valid_o ? r_mem[r_rd_ptr] : '0;
  assign level_o         = r_level;
  assign overflow_o      = r_ovf;
  assign words_written_o = r_words;

endmodule

// File: tb/tb_dma_sample_fifo.sv
// tb_dma_sample_fifo: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model of the sample FIFO.
module tb_dma_sample_fifo;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LVL_W = 7;

  logic             aclk = 1'b0;
  logic             rst_i;
  logic             clear_i;
  logic             capture_en_i;
  logic [15:0]      decim_i;
  logic [15:0]      sample_a_i;
  logic [15:0]      sample_b_i;
  logic             sample_valid_i;
  logic [63:0]      m_data_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [LVL_W-1:0] level_o;
  logic             overflow_o;
  logic [31:0]      words_written_o;

  always #5 aclk = ~aclk;

  dma_sample_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .aclk            (aclk),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .capture_en_i    (capture_en_i),
    .decim_i         (decim_i),
    .sample_a_i      (sample_a_i),
    .sample_b_i      (sample_b_i),
    .sample_valid_i  (sample_valid_i),
    .m_data_o        (m_data_o),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .level_o         (level_o),
    .overflow_o      (overflow_o),
    .words_written_o (words_written_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: a word queue, a pending low half, and the index of each
  // valid strobe within the current capture (kept when index mod (decim+1) == 0).
  logic [63:0] mq[$];
  bit          m_half;
  logic [31:0] m_lo;
  longint      m_k;
  logic [15:0] m_d;
  bit          m_prev_en;
  bit          m_ovf;
  logic [31:0] m_ww;

  task automatic model_reset();
    mq.delete();
    m_half = 0; m_lo = '0; m_k = 0; m_d = '0;
    m_prev_en = 0; m_ovf = 0; m_ww = '0;
  endtask

  task automatic model_edge();
    bit rise, pop, keep, full;
    rise = capture_en_i && !m_prev_en;
    pop  = (mq.size() != 0) && m_ready_i;
    if (rise) begin m_d = decim_i; m_k = 0; end
    if (clear_i) begin
      mq.delete(); m_half = 0; m_k = 0; m_ovf = 0; m_ww = '0;
    end else begin
      keep = 0;
      if (capture_en_i && sample_valid_i) begin
        keep = ((m_k % (longint'(m_d) + 1)) == 0);
        m_k++;
      end
      full = (mq.size() >= DEPTH);
      if (pop) void'(mq.pop_front());
      if (!capture_en_i) m_half = 0;
      else if (keep) begin
        if (!m_half) begin
          m_lo = {sample_a_i, sample_b_i};
          m_half = 1;
        end else begin
          m_half = 0;
          if (!full || pop) begin
            mq.push_back({sample_a_i, sample_b_i, m_lo});
            m_ww++;
          end else m_ovf = 1;
        end
      end
    end
    m_prev_en = capture_en_i;
  endtask

  task automatic check_all();
    chk("valid", 64'(m_valid_o), 64'(mq.size() != 0));
    chk("level", 64'(level_o), 64'(mq.size()));
    chk("data", m_data_o, (mq.size() != 0) ? mq[0] : 64'd0);
    chk("overflow", 64'(overflow_o), 64'(m_ovf));
    chk("words", 64'(words_written_o), 64'(m_ww));
  endtask

  task automatic step();
    model_edge();
    @(posedge aclk);
    #1;
    check_all();
  endtask

  task automatic pair(input logic [15:0] a, input logic [15:0] b);
    sample_valid_i = 1'b1;
    sample_a_i = a;
    sample_b_i = b;
    step();
    sample_valid_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; capture_en_i = 1'b0; decim_i = '0;
    sample_a_i = '0; sample_b_i = '0; sample_valid_i = 1'b0; m_ready_i = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_valid", 64'(m_valid_o), 64'd0);
    chk("rst_data", m_data_o, 64'd0);
    chk("rst_level", 64'(level_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_words", 64'(words_written_o), 64'd0);
    rst_i = 1'b0;

    // 1: decim=0, two pairs form one word
    decim_i = 16'd0; capture_en_i = 1'b1;
    step();
    pair(16'h0001, 16'h0002);
    pair(16'h0003, 16'h0004);
    chk("t1_data", m_data_o, 64'h0003_0004_0001_0002);
    chk("t1_valid", 64'(m_valid_o), 64'd1);
    chk("t1_level", 64'(level_o), 64'd1);
    chk("t1_words", 64'(words_written_o), 64'd1);

    // 2: decim=3 keeps strobes 0,4,8,12
    do_clear();
    capture_en_i = 1'b0; step();
    decim_i = 16'd3; capture_en_i = 1'b1; step();
    for (int i = 0; i < 16; i++) pair(16'(i), 16'(16'h100 + i));
    chk("t2_level", 64'(level_o), 64'd2);
    chk("t2_head", m_data_o, {16'd4, 16'h104, 16'd0, 16'h100});

    // 3: overfill by one word, then drain in order
    do_clear();
    capture_en_i = 1'b0; step();
    decim_i = 16'd0; capture_en_i = 1'b1; m_ready_i = 1'b0; step();
    for (int i = 0; i < 130; i++) pair(16'($urandom), 16'($urandom));
    chk("t3_level", 64'(level_o), 64'd64);
    chk("t3_ovf", 64'(overflow_o), 64'd1);
    chk("t3_words", 64'(words_written_o), 64'd64);
    capture_en_i = 1'b0; m_ready_i = 1'b1;
    for (int i = 0; i < 64; i++) step();
    chk("t3_empty", 64'(m_valid_o), 64'd0);
    m_ready_i = 1'b0;

    // 4: word completes at full level in the same cycle as a pop
    do_clear();
    capture_en_i = 1'b1; step();
    for (int i = 0; i < 129; i++) pair(16'($urandom), 16'($urandom));
    m_ready_i = 1'b1;
    pair(16'hBEEF, 16'hCAFE);
    m_ready_i = 1'b0;
    chk("t4_level", 64'(level_o), 64'd64);
    chk("t4_ovf", 64'(overflow_o), 64'd0);
    chk("t4_words", 64'(words_written_o), 64'd65);

    // 5: stale half discarded across capture restart
    do_clear();
    capture_en_i = 1'b0; step();
    capture_en_i = 1'b1; step();
    pair(16'hAAAA, 16'hBBBB);
    capture_en_i = 1'b0; step();
    capture_en_i = 1'b1; step();
    pair(16'h1111, 16'h2222);
    pair(16'h3333, 16'h4444);
    chk("t5_data", m_data_o, 64'h3333_4444_1111_2222);

    // 6: clear coinciding with a push at level 5, then async reset mid-burst
    do_clear();
    for (int i = 0; i < 11; i++) pair(16'($urandom), 16'($urandom));
    chk("t6_level5", 64'(level_o), 64'd5);
    clear_i = 1'b1;
    pair(16'h5555, 16'h6666);
    clear_i = 1'b0;
    chk("t6_clr_level", 64'(level_o), 64'd0);
    chk("t6_clr_valid", 64'(m_valid_o), 64'd0);
    chk("t6_clr_words", 64'(words_written_o), 64'd0);
    for (int i = 0; i < 7; i++) pair(16'($urandom), 16'($urandom));
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(m_valid_o), 64'd0);
    chk("t6_rst_data", m_data_o, 64'd0);
    chk("t6_rst_level", 64'(level_o), 64'd0);
    chk("t6_rst_words", 64'(words_written_o), 64'd0);
    model_reset();
    capture_en_i = 1'b0;
    @(posedge aclk);
    #1;
    rst_i = 1'b0;

    // Randomized traffic
    for (int ph = 0; ph < 6; ph++) begin
      int unsigned rdy_pct;
      rdy_pct = (ph % 2 == 0) ? 15 : 70;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(19, 0) == 0) begin
          capture_en_i = ~capture_en_i;
          decim_i = 16'($urandom_range(3, 0));
        end
        clear_i        = ($urandom_range(299, 0) == 0);
        sample_valid_i = ($urandom_range(1, 0) == 1);
        sample_a_i     = 16'($urandom);
        sample_b_i     = 16'($urandom);
        m_ready_i      = ($urandom_range(99, 0) < rdy_pct);
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dma_sample_fifo.md
Name: dma_sample_fifo

Overview:
Upstream feeder for the HP0 DMA write engine. It decimates ADC/PDH sample pairs and packs two kept pairs into each 64-bit word. Words are buffered in a first-word-fall-through FIFO, and the DMA engine pulls one word per accepted AXI write beat over a valid/ready interface. Word counting and sticky overflow reporting let software tell whether a capture buffer is gap-free.

Parameters:
DEPTH, 64, FIFO depth in 64-bit words; power of two, minimum 4.
LVL_W, $clog2(DEPTH)+1, width of level_o.

Ports:
aclk  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
clear_i  in  1  synchronous flush of FIFO, packer, counters and flags
capture_en_i  in  1  level; samples are kept only while high
decim_i  in  16  decimation: keep 1 of every decim_i+1 valid pairs; latched on capture_en_i rising edge
sample_a_i  in  16  channel A sample
sample_b_i  in  16  channel B sample
sample_valid_i  in  1  one-cycle strobe qualifying sample_a_i/sample_b_i
m_data_o  out  64  FIFO head word
m_valid_o  out  1  FIFO not empty
m_ready_i  in  1  consumer pop; a pop occurs when m_valid_o && m_ready_i
level_o  out  LVL_W  stored word count, 0..DEPTH
overflow_o  out  1  sticky: a completed word was dropped
words_written_o  out  32  count of words accepted into the FIFO since the last clear/reset; wraps modulo 2^32

Behaviour:
- Reset values: m_valid_o=0, m_data_o=0, level_o=0, overflow_o=0, words_written_o=0. Internal pointers, packer half-flag, decimation counter, latched decimation and capture_en edge register are all 0.
- Priority: rst_i > clear_i > normal operation. clear_i takes effect in one cycle: the FIFO empties, the partial half-word is discarded, the decimation counter goes to 0, and overflow_o and words_written_o go to 0. A push or pop in the same cycle as clear_i is ignored.
- Decimation:
  - On a capture_en_i rising edge, decim_i is latched and the decimation counter is set to 0.
  - A pair is kept when capture_en_i && sample_valid_i && counter==0. The counter then loads the latched decim value.
  - On any other valid strobe while enabled, the counter decrements.
  - decim=0 keeps every pair.
- Packing:
  - The first kept pair goes to bits [31:0] as {a,b}, with a in [31:16].
  - The second kept pair goes to [63:32] as {a,b}, with a in [63:48], and completes the word.
  - When capture_en_i falls, any half-filled word is discarded. The next capture starts in the low half.
- Push:
  - A completed word is written on the same edge that captures the second pair.
  - It is accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow_o is set. overflow_o stays set until clear/reset.
  - words_written_o increments only on an accepted push.
- FWFT read:
  - m_data_o = head word, m_valid_o = (level!=0).
  - The data stays stable while m_valid_o && !m_ready_i.
  - m_data_o is 0 when empty.
- Latency: the second kept pair is sampled at edge N. If the FIFO was empty, m_valid_o=1 with that word on m_data_o after edge N.
- Level:
  - push only: +1.
  - pop only: -1.
  - Simultaneous push and pop: level unchanged, data order preserved.
  - Push and pop at level 1: the new word becomes the head after the edge.
- Pointers wrap modulo DEPTH. level_o is the only full/empty indicator.
- m_ready_i while empty has no effect.
- rst_i asserted mid-operation: all state returns to reset values immediately, without waiting for a clock.

Test Plan:
1. decim=0, capture on, pairs (A,B)=(0x0001,0x0002),(0x0003,0x0004) -> one word, m_data_o=0x0003_0004_0001_0002, m_valid_o=1 after 2nd strobe edge, level_o=1, words_written_o=1.
2. decim=3, 16 consecutive valid strobes -> pairs 0,4,8,12 kept -> 2 words; strobes 1-3, 5-7, 9-11 and 13-15 ignored.
3. m_ready_i=0, DEPTH=64, push 65 words -> level_o=64, overflow_o=1, words_written_o=64. Then drain with m_ready_i=1 -> first 64 words in order, m_valid_o=0 after the last pop.
4. At level 64, complete a word in the same cycle as a pop -> accepted, level stays 64, overflow_o stays 0.
5. Drop capture_en_i after one kept pair, re-enable, feed pairs P,Q -> word = {Q,P}; the stale half is discarded.
6. Assert clear_i in the same cycle as a push while level=5 -> level_o=0, m_valid_o=0, words_written_o=0. Assert rst_i asynchronously mid-burst -> all outputs 0 before the next edge.
